lcu_key_sequencer: RTL

LCU_KEY_SEQUENCER -- requirements
Module: lcu_key_sequencer

---
 rtl/lcu_seq_pkg.sv | 19 +
 rtl/lcu_key_shifter.sv | 53 +++++
 rtl/lcu_key_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lcu_seq_pkg.sv
// lcu_seq_pkg: shared definitions for the logic-locking key sequencer.
//   - default parameter values for key width, reset hold length and run budget
//   - sequencer state encoding
package lcu_seq_pkg;

  localparam int unsigned KEY_W_DEF    = 8;
  localparam int unsigned HOLD_CYC_DEF = 2;
  localparam int unsigned RUN_MAX_DEF  = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArmed,
    StHold,
    StRun,
    StError
  } seq_state_e;

endpackage

// File: rtl/lcu_key_shifter.sv
// lcu_key_shifter: serial key staging register with bit counter and length check.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_shift         accept a key bit this cycle (handshake)
//   i_first         bit starts a new key (counter restarts at 1)
//   i_bit, i_last   key data bit and end-of-key marker
//   o_stage_next    staging value after this bit, used for the commit
//   o_commit        last bit arrived at exactly KEY_W bits
//   o_len_err       key length violation on this bit
module lcu_key_shifter #(
  parameter int unsigned KEY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift,
  input  logic             i_first,
  input  logic             i_bit,
  input  logic             i_last,
  output logic [KEY_W-1:0] o_stage_next,
  output logic             o_commit,
  output logic             o_len_err
);

  // Counter must reach KEY_W + 1 for the overlong check.
  localparam int unsigned CntW = $clog2(KEY_W + 2);
  localparam logic [CntW-1:0] LenFull = CntW'(KEY_W);
  localparam logic [CntW-1:0] LenOver = CntW'(KEY_W + 1);

  logic [KEY_W-1:0] r_stage;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_inc;
  logic [KEY_W:0]   w_cat;

  always_comb begin
    w_cnt_inc    = r_cnt + CntW'(1);
    w_cat        = {r_stage, i_bit};
    o_stage_next = i_first ? KEY_W'(i_bit) : w_cat[KEY_W-1:0];
    o_commit     = i_shift && !i_first && i_last && (w_cnt_inc == LenFull);
    o_len_err    = i_shift && !i_first &&
                   ((i_last && (w_cnt_inc != LenFull)) || (!i_last && (w_cnt_inc == LenOver)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_stage <= o_stage_next;
      r_cnt   <= i_first ? CntW'(1) : w_cnt_inc;
    end
  end

endmodule

// File: rtl/lcu_key_sequencer.sv
// lcu_key_sequencer: loads a serial unlock key, then sequences reset and run of a
// logic-locked controller.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   key_valid, key_bit, key_last     serial key stream (MSB first)
//   key_ready                        key bit accepted this cycle
//   start, stop, clear               run request, early stop, leave ERROR
//   lcu_rst                          active-high reset to the locked controller
//   key_out                          committed key
//   busy, done, err                  HOLD/RUN, end-of-run pulse, ERROR
//   run_cnt                          cycles spent in current/last RUN
module lcu_key_sequencer
  import lcu_seq_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned RUN_MAX  = RUN_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic             key_last,
  output logic             key_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             lcu_rst,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      run_cnt
);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [3:0]       r_hold_cnt;
  logic [15:0]      r_run_cnt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_done;

  logic             w_hs;
  logic             w_first;
  logic             w_hold_last;
  logic             w_run_end;
  logic [KEY_W-1:0] w_stage_next;
  logic             w_commit;
  logic             w_len_err;

  lcu_key_shifter #(
    .KEY_W(KEY_W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_shift     (w_hs),
    .i_first     (w_first),
    .i_bit       (key_bit),
    .i_last      (key_last),
    .o_stage_next(w_stage_next),
    .o_commit    (w_commit),
    .o_len_err   (w_len_err)
  );

  always_comb begin
    key_ready   = (r_state == StIdle) || (r_state == StLoad) || (r_state == StArmed);
    w_hs        = key_valid && key_ready;
    w_first     = (r_state != StLoad);
    w_hold_last = (r_hold_cnt == 4'(HOLD_CYC - 1));
    // stop and budget expiry in the same cycle still form a single run end
    w_run_end   = (r_state == StRun) && (stop || (r_run_cnt == 16'(RUN_MAX - 1)));

    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_hs) w_state_next = StLoad;
      StLoad: begin
        if (w_commit)       w_state_next = StArmed;
        else if (w_len_err) w_state_next = StError;
      end
      // a key handshake takes priority over a simultaneous start
      StArmed: begin
        if (w_hs)       w_state_next = StLoad;
        else if (start) w_state_next = StHold;
      end
      StHold:  if (w_hold_last) w_state_next = StRun;
      StRun:   if (w_run_end) w_state_next = StArmed;
      StError: if (clear) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase

    lcu_rst = (r_state != StRun);
    busy    = (r_state == StHold) || (r_state == StRun);
    err     = (r_state == StError);
    done    = r_done;
    key_out = r_key_out;
    run_cnt = r_run_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_run_cnt  <= '0;
      r_key_out  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_run_end;

      if (r_state == StHold) r_hold_cnt <= r_hold_cnt + 4'd1;
      else                   r_hold_cnt <= '0;

      if ((r_state == StArmed) && (w_state_next == StHold)) r_run_cnt <= '0;
      else if (r_state == StRun)                            r_run_cnt <= r_run_cnt + 16'd1;

      // key_out only moves on a clean commit or is wiped on a length error
      if (w_commit)       r_key_out <= w_stage_next;
      else if (w_len_err) r_key_out <= '0;
    end
  end

endmodule
